// File: rtl/sram_port_arb.sv
// -----------------------------------------------------------------------------
// sram_port_arb
//
// Shares one read/write SRAM port between two hosts (host 0: core data path,
// host 1: DMA / initialiser engine). Each cycle a single winner is chosen
// combinationally, its command is forwarded to the RAM, and the one-cycle
// response is steered back to whichever host issued it. Capability tags are
// only written when a full-word write carries them; any partial write clears
// the tag.
//
// Parameters
//   AddrWidth : byte-address width of the SRAM (word address = AddrWidth-2)
//   FixedPrio : 0 = round-robin, 1 = host 0 priority with host-1 relief
//   MaxWait   : FixedPrio=1 only; cycles host 1 may lose before it is forced
//               a grant (1..255)
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   hN_req_i / hN_gnt_o        request / same-cycle grant, N = 0, 1
//   hN_we_i, hN_be_i           write enable, byte enables
//   hN_addr_i                  word address
//   hN_wdata_i, hN_wcap_i      write data and capability tag
//   hN_rvalid_o                response valid (reads and writes)
//   hN_rdata_o, hN_rcap_o      read data and tag, zero when not valid
//   mem_*_o                    command to the RAM, all zero when idle
//   mem_rvalid_i, mem_rdata_i,
//   mem_rcap_i                 RAM response, one cycle after the command
//   err_o                      sticky: a response arrived with none pending
//   conflict_cnt_o             saturating count of two-host request cycles
// -----------------------------------------------------------------------------
module sram_port_arb #(
  parameter int AddrWidth = 17,
  parameter int FixedPrio = 0,
  parameter int MaxWait   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 h0_req_i,
  output logic                 h0_gnt_o,
  input  logic                 h0_we_i,
  input  logic [3:0]           h0_be_i,
  input  logic [AddrWidth-3:0] h0_addr_i,
  input  logic [31:0]          h0_wdata_i,
  input  logic                 h0_wcap_i,
  output logic                 h0_rvalid_o,
  output logic [31:0]          h0_rdata_o,
  output logic                 h0_rcap_o,

  input  logic                 h1_req_i,
  output logic                 h1_gnt_o,
  input  logic                 h1_we_i,
  input  logic [3:0]           h1_be_i,
  input  logic [AddrWidth-3:0] h1_addr_i,
  input  logic [31:0]          h1_wdata_i,
  input  logic                 h1_wcap_i,
  output logic                 h1_rvalid_o,
  output logic [31:0]          h1_rdata_o,
  output logic                 h1_rcap_o,

  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [AddrWidth-3:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic                 mem_wcap_o,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i,
  input  logic                 mem_rcap_i,

  output logic                 err_o,
  output logic [15:0]          conflict_cnt_o
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MaxWait);

  // Control state
  logic        rr_q;            // host granted most recently
  logic [7:0]  wait_q;          // cycles host 1 has been refused
  logic        pend_q;          // a response is due this cycle
  logic        owner_q;         // host that owns the pending response
  logic        err_q;
  logic        rst_d_q;         // high for the first cycle after reset
  logic [15:0] conflict_cnt_q;

  logic        gnt0;
  logic        gnt1;
  logic        any_gnt;
  logic        both_req;

  logic        sel_we;
  logic [3:0]  sel_be;
  logic [AddrWidth-3:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_wcap;

  logic        rsp_ok;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign both_req = h0_req_i & h1_req_i;

  // ---- Stage 0: arbitration and command mux (combinational) ----
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i) begin
      if (h0_req_i && !h1_req_i) begin
        gnt0 = 1'b1;
      end else if (h1_req_i && !h0_req_i) begin
        gnt1 = 1'b1;
      end else if (both_req) begin
        if (FixedPrio == 0) begin
          // rr_q holds the last winner, so the other host goes next
          if (rr_q) gnt0 = 1'b1;
          else      gnt1 = 1'b1;
        end else begin
          // Host 0 wins unless host 1 has been starved long enough
          if (wait_q >= MAX_WAIT_C) gnt1 = 1'b1;
          else                      gnt0 = 1'b1;
        end
      end
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign h0_gnt_o = gnt0;
  assign h1_gnt_o = gnt1;

  always_comb begin
    sel_we    = 1'b0;
    sel_be    = 4'h0;
    sel_addr  = '0;
    sel_wdata = 32'h0;
    sel_wcap  = 1'b0;
    if (gnt0) begin
      sel_we    = h0_we_i;
      sel_be    = h0_be_i;
      sel_addr  = h0_addr_i;
      sel_wdata = h0_wdata_i;
      sel_wcap  = h0_wcap_i;
    end else if (gnt1) begin
      sel_we    = h1_we_i;
      sel_be    = h1_be_i;
      sel_addr  = h1_addr_i;
      sel_wdata = h1_wdata_i;
      sel_wcap  = h1_wcap_i;
    end
  end

  assign mem_req_o   = any_gnt;
  assign mem_we_o    = sel_we;
  assign mem_be_o    = sel_be;
  assign mem_addr_o  = sel_addr;
  assign mem_wdata_o = sel_wdata;
  // A tag may only be set by a full-word write; partial writes clear it.
  assign mem_wcap_o  = sel_wcap & sel_we & (sel_be == 4'hF);

  // ---- Stage 0 -> 1: control registers ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q           <= 1'b1;
      wait_q         <= 8'h00;
      pend_q         <= 1'b0;
      owner_q        <= 1'b0;
      err_q          <= 1'b0;
      rst_d_q        <= 1'b1;
      conflict_cnt_q <= 16'h0000;
    end else begin
      rst_d_q <= 1'b0;

      if (gnt0)      rr_q <= 1'b0;
      else if (gnt1) rr_q <= 1'b1;

      if (h1_req_i && !gnt1) wait_q <= sat_inc8(wait_q);
      else                   wait_q <= 8'h00;

      pend_q <= any_gnt;
      if (any_gnt) owner_q <= gnt1;

      // The first post-reset cycle may carry a response to a command issued
      // just as reset arrived; it is dropped without raising an error.
      if (mem_rvalid_i && !pend_q && !rst_d_q) err_q <= 1'b1;

      if (both_req) conflict_cnt_q <= sat_inc16(conflict_cnt_q);
    end
  end

  // ---- Stage 1: response routing ----
  assign rsp_ok = mem_rvalid_i & pend_q & ~rst_i;

  assign h0_rvalid_o = rsp_ok & ~owner_q;
  assign h1_rvalid_o = rsp_ok &  owner_q;
  assign h0_rdata_o  = h0_rvalid_o ? mem_rdata_i : 32'h0;
  assign h1_rdata_o  = h1_rvalid_o ? mem_rdata_i : 32'h0;
  assign h0_rcap_o   = h0_rvalid_o & mem_rcap_i;
  assign h1_rcap_o   = h1_rvalid_o & mem_rcap_i;

  assign err_o          = err_q;
  assign conflict_cnt_o = conflict_cnt_q;

endmodule
